// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and data
// accesses; data has priority, bounded by a fetch anti-starvation limit.
module mem_port_arbiter #(
  parameter int LATENCY      = 4,
  parameter int STARVE_LIMIT = 3,
  parameter int WORD         = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_req,
  input  logic [WORD-1:0] i_addr,
  output logic            i_done,
  output logic [WORD-1:0] i_rdata,
  input  logic            d_req,
  input  logic            d_write,
  input  logic [WORD-1:0] d_addr,
  input  logic [WORD-1:0] d_wdata,
  output logic            d_done,
  output logic [WORD-1:0] d_rdata,
  output logic            mem_read,
  output logic            mem_write,
  output logic [WORD-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  input  logic [WORD-1:0] mem_rdata,
  output logic            busy,
  output logic            owner
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(LATENCY - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve;
  logic          wr;
  logic          fetch_wins;

  // Fetch wins when alone, or when it has lost STARVE_LIMIT contested rounds in a row.
  assign fetch_wins = i_req & (~d_req | (starve == STARVE_MAX));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      starve    <= '0;
      wr        <= 1'b0;
      owner     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            state <= ACCESS;
            cnt   <= '0;
            if (fetch_wins) begin
              owner     <= 1'b0;
              wr        <= 1'b0;
              mem_addr  <= i_addr;
              mem_wdata <= '0;
              starve    <= '0;
            end else begin
              owner     <= 1'b1;
              wr        <= d_write;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              if (i_req && starve != STARVE_MAX) starve <= starve + SW'(1);
            end
          end
        end
        ACCESS: begin
          if (cnt == LAST_CNT) begin
            state <= DONE;
            if (!wr) begin
              if (owner) d_rdata <= mem_rdata;
              else       i_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign mem_read  = (state == ACCESS) & ~wr;
  assign mem_write = (state == ACCESS) &  wr;
  assign i_done    = (state == DONE) & ~owner;
  assign d_done    = (state == DONE) &  owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a cycle-timeline
// reference model (elapsed cycles since grant).
module tb_mem_port_arbiter;
  localparam int LAT = 4;
  localparam int SL  = 3;
  localparam int W   = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_req, d_req, d_write;
  logic [W-1:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic         i_done, d_done, mem_read, mem_write, busy, owner;
  logic [W-1:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  int checks   = 0;
  int failures = 0;

  // model: m_t = cycles since grant (0 idle, 1..LAT strobes, LAT+1 done)
  int           m_t = 0;
  logic         m_owner = 1'b0, m_write = 1'b0;
  logic [W-1:0] m_addr = '0, m_wdata = '0, m_irdata = '0, m_drdata = '0;
  int           m_starve = 0;

  mem_port_arbiter #(.LATENCY(LAT), .STARVE_LIMIT(SL), .WORD(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Advance the reference model with the inputs the DUT sees at this edge, then clock.
  task automatic tick();
    if (!reset_n) begin
      m_t = 0; m_owner = 0; m_write = 0; m_addr = '0; m_wdata = '0;
      m_starve = 0; m_irdata = '0; m_drdata = '0;
    end else if (m_t == 0) begin
      if (i_req || d_req) begin
        if (i_req && (!d_req || m_starve == SL)) begin
          m_owner = 0; m_write = 0; m_addr = i_addr; m_wdata = '0; m_starve = 0;
        end else begin
          m_owner = 1; m_write = d_write; m_addr = d_addr; m_wdata = d_wdata;
          if (i_req && m_starve < SL) m_starve = m_starve + 1;
        end
        m_t = 1;
      end
    end else if (m_t <= LAT) begin
      if (m_t == LAT && !m_write) begin
        if (m_owner) m_drdata = mem_rdata;
        else         m_irdata = mem_rdata;
      end
      m_t = m_t + 1;
    end else begin
      m_t = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 0; i_req = 0; d_req = 0; d_write = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    tick(); tick();
    reset_n = 1;
    checks++;
    if ({busy, owner, mem_read, mem_write, i_done, d_done} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=000000", {busy, owner, mem_read, mem_write, i_done, d_done});
    end
    checks++;
    if ({i_rdata, d_rdata, mem_addr, mem_wdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_data got=%h want=0", {i_rdata, d_rdata, mem_addr, mem_wdata});
    end
  endtask

  task automatic test_single_fetch();
    i_req = 1; i_addr = 16'h0010;
    for (int c = 1; c <= LAT + 1; c++) begin
      mem_rdata = (c == LAT + 1) ? 16'hA5A5 : 16'h0000;
      tick();
      checks++;
      if (c <= LAT) begin
        if ({busy, mem_read, mem_write, i_done, d_done} !== 5'b11000 || mem_addr !== 16'h0010 || i_rdata !== 16'h0) begin
          failures++;
          $display("FAIL fetch_access c=%0d got ctl=%b addr=%h rd=%h want ctl=11000 addr=0010 rd=0000",
                   c, {busy, mem_read, mem_write, i_done, d_done}, mem_addr, i_rdata);
        end
      end else begin
        if ({mem_read, i_done, d_done} !== 3'b010 || i_rdata !== 16'hA5A5) begin
          failures++;
          $display("FAIL fetch_done got ctl=%b rd=%h want ctl=010 rd=a5a5", {mem_read, i_done, d_done}, i_rdata);
        end
      end
    end
    i_req = 0;
    tick();
    checks++;
    if ({busy, i_done} !== 2'b00) begin
      failures++;
      $display("FAIL fetch_idle got=%b want=00", {busy, i_done});
    end
  endtask

  task automatic test_simultaneous();
    int dt = -1, it = -1;
    i_req = 1; i_addr = 16'h0100;
    d_req = 1; d_write = 0; d_addr = 16'h0200;
    for (int t = 1; t <= 30; t++) begin
      mem_rdata = mem_addr ^ 16'hBE00;
      tick();
      if (t == 1) begin
        checks++;
        if (owner !== 1'b1 || mem_addr !== 16'h0200) begin
          failures++;
          $display("FAIL joint_grant got owner=%b addr=%h want owner=1 addr=0200", owner, mem_addr);
        end
      end
      if (i_done && d_done) begin
        checks++; failures++;
        $display("FAIL joint_both_done t=%0d", t);
      end
      if (d_done) begin dt = t; d_req = 0; end
      if (i_done) begin it = t; i_req = 0; break; end
    end
    checks++;
    if (dt != LAT + 1 || it != 2 * LAT + 3) begin
      failures++;
      $display("FAIL joint_timing got d=%0d i=%0d want d=%0d i=%0d", dt, it, LAT + 1, 2 * LAT + 3);
    end
    checks++;
    if (d_rdata !== 16'hBC00 || i_rdata !== 16'hBF00) begin
      failures++;
      $display("FAIL joint_rdata got d=%h i=%h want d=bc00 i=bf00", d_rdata, i_rdata);
    end
    tick();
  endtask

  task automatic test_store();
    d_req = 1; d_write = 1; d_addr = 16'h0040; d_wdata = 16'h1234; mem_rdata = 16'hFFFF;
    for (int c = 1; c <= LAT + 1; c++) begin
      tick();
      checks++;
      if (c <= LAT) begin
        if ({mem_read, mem_write, d_done} !== 3'b010 || mem_addr !== 16'h0040 || mem_wdata !== 16'h1234) begin
          failures++;
          $display("FAIL store_access c=%0d got ctl=%b addr=%h wd=%h want ctl=010 addr=0040 wd=1234",
                   c, {mem_read, mem_write, d_done}, mem_addr, mem_wdata);
        end
      end else begin
        if ({mem_write, d_done, i_done} !== 3'b010 || d_rdata !== 16'hBC00) begin
          failures++;
          $display("FAIL store_done got ctl=%b rd=%h want ctl=010 rd=bc00", {mem_write, d_done, i_done}, d_rdata);
        end
      end
    end
    d_req = 0; d_write = 0;
    tick();
  endtask

  task automatic test_starvation();
    logic q[$];
    logic prev_busy = 1'b0;
    logic exp_q[8] = '{1, 1, 1, 0, 1, 1, 1, 0};
    i_req = 1; d_req = 1; d_write = 0;
    for (int t = 0; t < 120 && q.size() < 8; t++) begin
      i_addr = W'($urandom); d_addr = W'($urandom);
      tick();
      if (busy && !prev_busy) q.push_back(owner);
      prev_busy = busy;
      if (d_done) d_req = 0;
      if (i_done) i_req = 0;
      if (!busy) begin d_req = 1; i_req = 1; end
    end
    i_req = 0; d_req = 0;
    checks++;
    if (q.size() != 8) begin
      failures++;
      $display("FAIL starve_count got=%0d grants want=8", q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (q[k] !== exp_q[k]) begin
          failures++;
          $display("FAIL starve_grant k=%0d got owner=%b want=%b", k, q[k], exp_q[k]);
        end
      end
    end
    for (int t = 0; t < LAT + 2; t++) tick();
  endtask

  task automatic test_addr_change();
    i_req = 1; i_addr = 16'h0010; mem_rdata = 16'h0F0F;
    tick();
    i_addr = 16'h0020;
    for (int c = 1; c <= LAT; c++) begin
      checks++;
      if (mem_addr !== 16'h0010 || mem_read !== 1'b1) begin
        failures++;
        $display("FAIL addr_hold c=%0d got addr=%h rd=%b want addr=0010 rd=1", c, mem_addr, mem_read);
      end
      tick();
    end
    checks++;
    if (i_done !== 1'b1 || i_rdata !== 16'h0F0F) begin
      failures++;
      $display("FAIL addr_done got done=%b rd=%h want done=1 rd=0f0f", i_done, i_rdata);
    end
    i_req = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    int found = 0;
    d_req = 1; d_write = 0; d_addr = 16'h0077; mem_rdata = 16'h1111;
    tick(); tick();
    reset_n = 0;
    tick();
    reset_n = 1;
    checks++;
    if ({busy, mem_read, d_done} !== 3'b000 || d_rdata !== 16'h0 || i_rdata !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid got ctl=%b drd=%h ird=%h want ctl=000 drd=0 ird=0", {busy, mem_read, d_done}, d_rdata, i_rdata);
    end
    mem_rdata = 16'h2222;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (d_done) begin found = t + 1; break; end
    end
    checks++;
    if (found != LAT + 1 || d_rdata !== 16'h2222) begin
      failures++;
      $display("FAIL reset_rereq got t=%0d rd=%h want t=%0d rd=2222", found, d_rdata, LAT + 1);
    end
    d_req = 0;
    tick();
  endtask

  task automatic test_random();
    logic exp_busy, exp_rd, exp_wr, exp_id, exp_dd;
    for (int n = 0; n < 800; n++) begin
      if (i_done) i_req = 0;
      else if (!i_req && $urandom_range(0, 2) == 0) begin i_req = 1; i_addr = W'($urandom); end
      if (d_done) d_req = 0;
      else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_write = 1'($urandom); d_addr = W'($urandom); d_wdata = W'($urandom);
      end
      mem_rdata = W'($urandom);
      reset_n = ($urandom_range(0, 99) != 0);
      tick();
      exp_busy = (m_t != 0);
      exp_rd   = (m_t >= 1 && m_t <= LAT) && !m_write;
      exp_wr   = (m_t >= 1 && m_t <= LAT) &&  m_write;
      exp_id   = (m_t == LAT + 1) && !m_owner;
      exp_dd   = (m_t == LAT + 1) &&  m_owner;
      checks++;
      if ({busy, mem_read, mem_write, i_done, d_done} !== {exp_busy, exp_rd, exp_wr, exp_id, exp_dd}) begin
        failures++;
        $display("FAIL rand_ctl n=%0d got=%b want=%b", n, {busy, mem_read, mem_write, i_done, d_done},
                 {exp_busy, exp_rd, exp_wr, exp_id, exp_dd});
      end
      checks++;
      if (i_rdata !== m_irdata || d_rdata !== m_drdata) begin
        failures++;
        $display("FAIL rand_rdata n=%0d got i=%h d=%h want i=%h d=%h", n, i_rdata, d_rdata, m_irdata, m_drdata);
      end
      if (exp_busy) begin
        checks++;
        if (owner !== m_owner || mem_addr !== m_addr || (m_write && mem_wdata !== m_wdata)) begin
          failures++;
          $display("FAIL rand_grant n=%0d got own=%b addr=%h wd=%h want own=%b addr=%h wd=%h",
                   n, owner, mem_addr, mem_wdata, m_owner, m_addr, m_wdata);
        end
      end
    end
    reset_n = 1;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_store();
    test_starvation();
    test_addr_change();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
